// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads instruction memory and buffers words in a
// small prefetch FIFO for decode. Define IFU_PERF_COUNTERS_EN to add fetch/flush counters.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic        imem_write,
  output logic [31:0] imem_address,
  output logic [31:0] imem_write_data,
  input  logic [31:0] imem_read_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  input  logic        freeze,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     fetch_pc_q;
  logic [31:0]     instr_mem_q [FIFO_DEPTH];
  logic [31:0]     pc_mem_q    [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            empty, full, pop, push;
  logic [31:0]     next_pc, target_pc;
  logic            unused_addr_bits;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign pop       = ~empty & ~freeze;
  assign push      = ~branch_taken & (~full | pop);
  assign next_pc   = fetch_pc_q + 32'd4;
  assign target_pc = {branch_address[31:2], 2'b00};
  assign unused_addr_bits = ^branch_address[1:0];

  // Reset is asynchronous, so the strobe must drop without waiting for a clock edge.
  assign imem_read       = push & ~rst;
  assign imem_write      = 1'b0;
  assign imem_address    = fetch_pc_q;
  assign imem_write_data = 32'h0;

  assign if_valid       = ~empty;
  assign if_instruction = empty ? 32'h0 : instr_mem_q[rd_ptr_q];
  assign if_pc          = empty ? 32'h0 : pc_mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (branch_taken) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      count_q <= count_d;
      if (branch_taken) begin
        fetch_pc_q <= target_pc;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
      end else begin
        if (push) begin
          fetch_pc_q <= next_pc;
          wr_ptr_q   <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
      end
    end
  end

  // Payload storage needs no reset: entries are only observed through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_read_data;
      pc_mem_q[wr_ptr_q]    <= next_pc;
    end
  end

`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q, flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (push) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (branch_taken) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a queue-based reference model, plus a
// second instance with RESET_PC near the top of the address space to cover PC wrap.
module tb_instruction_fetch_unit;

  localparam int unsigned Depth  = 2;
  localparam logic [31:0] WrapPc = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_read, imem_write;
  logic [31:0] imem_address, imem_write_data, imem_read_data;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        freeze;
  logic        if_valid;
  logic [31:0] if_instruction, if_pc;
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] fetch_count, flush_count;
  logic [31:0] w_fetch_count, w_flush_count;
`endif

  logic        w_read, w_write, w_valid;
  logic [31:0] w_address, w_write_data, w_read_data, w_instruction, w_if_pc;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [63:0] model_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_fetches, model_flushes;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_read_data = mem_word(imem_address);
  assign w_read_data    = mem_word(w_address);

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(Depth)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_read      (imem_read),
    .imem_write     (imem_write),
    .imem_address   (imem_address),
    .imem_write_data(imem_write_data),
    .imem_read_data (imem_read_data),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .freeze         (freeze),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc)
`ifdef IFU_PERF_COUNTERS_EN
    ,
    .fetch_count    (fetch_count),
    .flush_count    (flush_count)
`endif
  );

  instruction_fetch_unit #(
    .RESET_PC  (WrapPc),
    .FIFO_DEPTH(Depth)
  ) u_dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_read      (w_read),
    .imem_write     (w_write),
    .imem_address   (w_address),
    .imem_write_data(w_write_data),
    .imem_read_data (w_read_data),
    .branch_taken   (1'b0),
    .branch_address (32'h0),
    .freeze         (1'b0),
    .if_valid       (w_valid),
    .if_instruction (w_instruction),
    .if_pc          (w_if_pc)
`ifdef IFU_PERF_COUNTERS_EN
    ,
    .fetch_count    (w_fetch_count),
    .flush_count    (w_flush_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_pc      = 32'h0;
    model_fetches = 32'h0;
    model_flushes = 32'h0;
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model, cross the edge.
  task automatic step(input logic br, input logic [31:0] ba, input logic frz);
    logic        exp_valid, exp_push;
    logic [63:0] head;
    branch_taken   = br;
    branch_address = ba;
    freeze         = frz;
    @(negedge clk);
    exp_valid = (model_q.size() != 0);
    head      = exp_valid ? model_q[0] : 64'h0;
    exp_push  = !br && ((model_q.size() < int'(Depth)) || (exp_valid && !frz));
    check_eq("imem_read", {31'h0, imem_read}, {31'h0, exp_push});
    check_eq("imem_address", imem_address, model_pc);
    check_eq("if_valid", {31'h0, if_valid}, {31'h0, exp_valid});
    check_eq("if_instruction", if_instruction, head[63:32]);
    check_eq("if_pc", if_pc, head[31:0]);
    check_eq("imem_write", {31'h0, imem_write} | imem_write_data, 32'h0);
`ifdef IFU_PERF_COUNTERS_EN
    check_eq("fetch_count", fetch_count, model_fetches);
    check_eq("flush_count", flush_count, model_flushes);
`endif
    if (br) begin
      model_q.delete();
      model_pc = {ba[31:2], 2'b00};
      model_flushes++;
    end else begin
      if (exp_valid && !frz) void'(model_q.pop_front());
      if (exp_push) begin
        model_q.push_back({mem_word(model_pc), model_pc + 32'd4});
        model_pc = model_pc + 32'd4;
        model_fetches++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    branch_taken = 1'b0;
    branch_address = 32'h0;
    freeze = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'h0, if_valid}, 32'h0);
    check_eq("rst_read", {31'h0, imem_read}, 32'h0);
    check_eq("rst_instr", if_instruction, 32'h0);
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_addr", imem_address, 32'h0);
    check_eq("rst_wrap_addr", w_address, WrapPc);
    rst = 1'b0;

    // Free run; also watch the wrapping instance.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        check_eq("wrap_addr", w_address, WrapPc + 32'd4 * k);
        check_eq("wrap_if_pc", w_if_pc, (k == 0) ? 32'h0 : WrapPc + 32'd4 * k);
      end
      step(1'b0, 32'h0, 1'b0);
    end

    // Freeze 4 cycles, release, then branch while full and frozen.
    repeat (4) step(1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0027, 1'b1);
    check_eq("br_addr", imem_address, 32'h24);
    check_eq("br_flush", {31'h0, if_valid}, 32'h0);
    step(1'b0, 32'h0, 1'b0);
    check_eq("br_instr", if_instruction, mem_word(32'h24));
    check_eq("br_if_pc", if_pc, 32'h28);

    // Back-to-back branches: last wins.
    step(1'b1, 32'h0000_0100, 1'b0);
    step(1'b1, 32'h0000_0203, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(9) == 0), $urandom, ($urandom_range(9) < 4));
    end

    // Reset mid-stream with two entries held and a branch pending.
    step(1'b0, 32'h0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b1);
    branch_taken   = 1'b1;
    branch_address = 32'h0000_0400;
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", {31'h0, if_valid}, 32'h0);
    check_eq("mid_rst_read", {31'h0, imem_read}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    repeat (10) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0040, 1'b0);
    step(1'b1, 32'h0000_0080, 1'b0);
`ifdef IFU_PERF_COUNTERS_EN
    check_eq("perf_fetch", fetch_count, 32'd10);
    check_eq("perf_flush", flush_count, 32'd2);
`endif
    repeat (4) step(1'b0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
